// File: rtl/fp_mc_ctrl.sv
`default_nettype none
// ============================================================================
// fp_mc_ctrl : FP execution-unit issue/sequencing controller (latency counter)
// Rev 1.0
// ============================================================================
module fp_mc_ctrl #(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CVT_LAT = 2,
    parameter int unsigned DIV_LAT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [3:0] issue_op,
    input  logic [4:0] issue_rd,
    input  logic       issue_fp_we,
    input  logic       issue_int_we,
    input  logic       flush,
    output logic       issue_ready,
    output logic       stall,
    output logic       start,
    output logic [3:0] unit_op,
    output logic       busy,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_fp_we,
    output logic       wb_int_we
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [4:0] lat;
    logic       accept;
    logic       lat_fp_we, lat_int_we;

    always_comb begin
        lat = 5'd1;
        case (issue_op)
            4'b0000, 4'b0001: lat = 5'(ADD_LAT);
            4'b0010:          lat = 5'(MUL_LAT);
            4'b1101, 4'b1110: lat = 5'(CVT_LAT);
            4'b1111:          lat = 5'(DIV_LAT);
            default:          lat = 5'd1;
        endcase
    end

    assign issue_ready = (state == IDLE || state == DONE) && !rst && !flush;
    assign accept      = issue_valid && issue_ready;
    assign stall       = issue_valid && !issue_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: state_n = IDLE;
            EXEC: begin
                cnt_n = cnt - 5'd1;
                if (cnt == 5'd1) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A DONE-cycle accept overrides the return to IDLE (back-to-back issue)
        if (accept) begin
            if (lat == 5'd1) begin
                state_n = DONE;
                cnt_n   = 5'd0;
            end else begin
                state_n = EXEC;
                cnt_n   = lat - 5'd1;
            end
        end
        if (flush) begin
            state_n = IDLE;
            cnt_n   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            start      <= 1'b0;
            unit_op    <= 4'd0;
            wb_rd      <= 5'd0;
            lat_fp_we  <= 1'b0;
            lat_int_we <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            start <= accept;
            if (accept) begin
                unit_op    <= issue_op;
                wb_rd      <= issue_rd;
                lat_fp_we  <= issue_fp_we;
                lat_int_we <= issue_int_we;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign wb_valid  = (state == DONE);
    assign wb_fp_we  = wb_valid && lat_fp_we;
    assign wb_int_we = wb_valid && lat_int_we;

endmodule
`default_nettype wire

// File: tb/tb_fp_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fp_mc_ctrl : self-checking bench for fp_mc_ctrl
// Rev 1.0
// ============================================================================
module tb_fp_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [3:0] issue_op;
    logic [4:0] issue_rd;
    logic       issue_fp_we;
    logic       issue_int_we;
    logic       flush;
    logic       issue_ready, stall, start, busy;
    logic [3:0] unit_op;
    logic       wb_valid, wb_fp_we, wb_int_we;
    logic [4:0] wb_rd;

    fp_mc_ctrl dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rd(issue_rd), .issue_fp_we(issue_fp_we), .issue_int_we(issue_int_we),
        .flush(flush), .issue_ready(issue_ready), .stall(stall), .start(start),
        .unit_op(unit_op), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_fp_we(wb_fp_we), .wb_int_we(wb_int_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [4:0] rd;
        logic       fw;
        logic       iw;
        int         due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] op;
        logic [4:0] rd;
        logic       fw;
        logic       iw;
        int         lat;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; an accepted op is pushed to the scoreboard with its due cycle.
    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                         input logic fw, input logic iw, input int lat,
                         input logic fl, input logic rs);
        exp_t e;
        @(negedge clk);
        issue_valid = v; issue_op = op; issue_rd = rd;
        issue_fp_we = fw; issue_int_we = iw; flush = fl; rst = rs;
        #1;
        if (fl || rs) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due > cyc) sb.delete(i);
        end
        if (v && issue_ready) begin
            e.rd = rd; e.fw = fw; e.iw = iw; e.due = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    endtask

    // Scoreboard: writebacks are compared against the queue in order and on time.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL sb_missing_wb: got none expected rd=%0d due cycle %0d", sb[0].rd, sb[0].due);
                void'(sb.pop_front());
            end
            if (wb_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected_wb: got wb rd=%0d expected none (cycle %0d)", wb_rd, cyc);
                end else begin
                    chk("sb_wb_cycle", cyc, sb[0].due);
                    chk("sb_wb_rd", wb_rd, sb[0].rd);
                    chk("sb_wb_fp_we", wb_fp_we, sb[0].fw);
                    chk("sb_wb_int_we", wb_int_we, sb[0].iw);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int k, n, stalls;
        bit got;
        rst = 1'b1; issue_valid = 1'b0; issue_op = 4'd0; issue_rd = 5'd0;
        issue_fp_we = 1'b0; issue_int_we = 1'b0; flush = 1'b0;

        vecs[0] = '{4'b0000, 5'd1,  1'b1, 1'b0, 2};
        vecs[1] = '{4'b0001, 5'd2,  1'b1, 1'b0, 2};
        vecs[2] = '{4'b0010, 5'd3,  1'b1, 1'b0, 3};
        vecs[3] = '{4'b0011, 5'd4,  1'b1, 1'b0, 1};
        vecs[4] = '{4'b0100, 5'd5,  1'b0, 1'b1, 1};
        vecs[5] = '{4'b1101, 5'd6,  1'b0, 1'b1, 2};
        vecs[6] = '{4'b1110, 5'd7,  1'b1, 1'b0, 2};
        vecs[7] = '{4'b1111, 5'd8,  1'b1, 1'b0, 16};
        vecs[8] = '{4'b0111, 5'd9,  1'b0, 1'b0, 1};
        vecs[9] = '{4'b1010, 5'd31, 1'b1, 1'b1, 1};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_unit_op", unit_op, 0);
        chk("rst_wb_rd", wb_rd, 0);
        idle();
        mon_en = 1'b1;
        chk("post_rst_ready", issue_ready, 1);

        // FADD rd=5, decode keeps presenting during the stall cycle
        drive(1'b1, 4'b0000, 5'd5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        k = cyc;
        drive(1'b1, 4'b0100, 5'd9, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        chk("fadd_start", start, 1);
        chk("fadd_stall", stall, 1);
        chk("fadd_unit_op", unit_op, 0);
        idle();
        chk("fadd_wb_valid", wb_valid, 1);
        chk("fadd_wb_rd", wb_rd, 5);
        chk("fadd_wb_fp_we", wb_fp_we, 1);
        chk("fadd_wb_cycle", cyc - k, 2);
        idle();
        chk("fadd_busy_after", busy, 0);

        // Three back-to-back FEQ
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'b0100, 5'(i), 1'b0, 1'b1, 1, 1'b0, 1'b0);
            chk("feq_ready", issue_ready, 1);
            chk("feq_stall", stall, 0);
            if (i > 1) chk("feq_wb_rd", wb_rd, i - 1);
        end
        idle();
        chk("feq_last_wb_valid", wb_valid, 1);
        chk("feq_last_wb_rd", wb_rd, 3);
        chk("feq_last_int_we", wb_int_we, 1);
        idle();

        // FDIV then FMUL presented until accepted in the FDIV DONE cycle
        drive(1'b1, 4'b1111, 5'd7, 1'b1, 1'b0, 16, 1'b0, 1'b0);
        k = cyc;
        stalls = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            drive(1'b1, 4'b0010, 5'd8, 1'b1, 1'b0, 3, 1'b0, 1'b0);
            if (issue_ready) got = 1'b1;
            else stalls += int'(stall);
        end
        chk("fdiv_accept_seen", int'(got), 1);
        chk("fdiv_stall_cycles", stalls, 15);
        chk("fdiv_done_cycle", cyc - k, 16);
        chk("fdiv_wb_valid", wb_valid, 1);
        chk("fdiv_wb_rd", wb_rd, 7);
        idle();
        chk("fmul_start", start, 1);
        chk("fmul_start_cycle", cyc - k, 17);
        chk("fmul_unit_op", unit_op, 4'b0010);
        idle();
        idle();
        chk("fmul_wb_cycle", cyc - k, 19);
        chk("fmul_wb_valid", wb_valid, 1);
        chk("fmul_wb_rd", wb_rd, 8);
        idle();

        // FMUL killed by flush in cycle 2
        drive(1'b1, 4'b0010, 5'd13, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        idle();
        drive(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        chk("flush_no_wb", wb_valid, 0);
        idle();
        chk("flush_busy", busy, 0);
        chk("flush_ready", issue_ready, 1);
        chk("flush_wb_after", wb_valid, 0);
        repeat (3) idle();

        // Reset in the middle of FDIV
        drive(1'b1, 4'b1111, 5'd14, 1'b1, 1'b0, 16, 1'b0, 1'b0);
        repeat (4) idle();
        drive(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        idle();
        chk("mrst_start", start, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_wb_valid", wb_valid, 0);
        chk("mrst_wb_rd", wb_rd, 0);
        chk("mrst_wb_fp_we", wb_fp_we, 0);
        chk("mrst_wb_int_we", wb_int_we, 0);
        chk("mrst_unit_op", unit_op, 0);
        drive(1'b1, 4'b0000, 5'd11, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        k = cyc;
        idle();
        chk("mrst_fadd_start", start, 1);
        idle();
        chk("mrst_fadd_wb", wb_valid, 1);
        chk("mrst_fadd_rd", wb_rd, 11);
        repeat (20) idle();

        // flush together with issue_valid in IDLE
        drive(1'b1, 4'b0000, 5'd12, 1'b1, 1'b0, 2, 1'b1, 1'b0);
        chk("fl_issue_ready", issue_ready, 0);
        idle();
        chk("fl_no_start", start, 0);
        chk("fl_busy", busy, 0);
        drive(1'b1, 4'b0000, 5'd12, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        chk("fl_reissue_ready", issue_ready, 1);
        idle();
        chk("fl_reissue_start", start, 1);
        repeat (2) idle();

        // Latency table over every encoding class
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].rd, vecs[i].fw, vecs[i].iw, vecs[i].lat, 1'b0, 1'b0);
            k = cyc;
            idle();
            chk("tbl_start", start, 1);
            chk("tbl_unit_op", unit_op, vecs[i].op);
            n = 0;
            for (int j = 0; j < 40 && !wb_valid; j++) begin
                idle();
                n++;
            end
            chk("tbl_latency", cyc - k, vecs[i].lat);
            chk("tbl_wb_rd", wb_rd, vecs[i].rd);
            idle();
        end

        repeat (3) idle();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
